// File: rtl/vga_timing_ctrl_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan-out timing block.
// Segment encodings are fixed; coordinate and segment counters are 10 bits wide.
package vga_timing_ctrl_pkg;

  typedef enum logic [1:0] {
    SEG_ACTIVE = 2'd0,
    SEG_FRONT  = 2'd1,
    SEG_SYNC   = 2'd2,
    SEG_BACK   = 2'd3
  } seg_state_e;

  localparam int COORD_W = 10;
  localparam int SEG_W   = 10;

  localparam int DEF_PIX_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SEG_W-1:0]   seg_cnt_t;

  // Registered scan-out bundle; irq lives outside it because it is optional.
  typedef struct packed {
    logic   pix_ce;
    logic   pix_valid;
    coord_t pix_x;
    coord_t pix_y;
    logic   hsync;
    logic   vsync;
    logic   hblank;
    logic   vblank;
    logic   line_start;
    logic   frame_start;
  } vga_out_t;

  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Register-block / pixel-path side of the VGA timing block.
// master = timing generator, slave = consumer that drives vga_en and irq_ack.
interface vga_timing_ctrl_if;

  logic                        vga_en;
  logic                        irq_ack;
  logic                        pix_ce;
  logic                        pix_valid;
  vga_timing_ctrl_pkg::coord_t pix_x;
  vga_timing_ctrl_pkg::coord_t pix_y;
  logic                        hsync;
  logic                        vsync;
  logic                        hblank;
  logic                        vblank;
  logic                        line_start;
  logic                        frame_start;
  logic                        irq;

  modport master (
    input  vga_en, irq_ack,
    output pix_ce, pix_valid, pix_x, pix_y, hsync, vsync,
           hblank, vblank, line_start, frame_start, irq
  );

  modport slave (
    output vga_en, irq_ack,
    input  pix_ce, pix_valid, pix_x, pix_y, hsync, vsync,
           hblank, vblank, line_start, frame_start, irq
  );

endinterface

// File: rtl/vga_timing_ctrl_seg_fsm.sv
// ACTIVE/FRONT/SYNC/BACK segment sequencer with per-segment counter.
// Latency: state/idx update on the adv edge; wrap is a same-cycle strobe.
// Backpressure: none, advances only when adv is high.
module vga_seg_fsm
  import vga_timing_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       adv,
  input  seg_cnt_t   len_active,
  input  seg_cnt_t   len_front,
  input  seg_cnt_t   len_sync,
  input  seg_cnt_t   len_back,
  output seg_state_e state,
  output seg_cnt_t   idx,
  output logic       wrap
);

  seg_cnt_t seg_len;
  logic     seg_last;

  always_comb begin
    seg_len = len_active;
    unique case (state)
      SEG_ACTIVE: seg_len = len_active;
      SEG_FRONT:  seg_len = len_front;
      SEG_SYNC:   seg_len = len_sync;
      SEG_BACK:   seg_len = len_back;
      default:    seg_len = len_active;
    endcase
  end

  assign seg_last = (idx == seg_len - SEG_W'(1));
  // Chained into the next sequencer so it steps exactly once per full cycle here.
  assign wrap     = adv && seg_last && (state == SEG_BACK);

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= SEG_ACTIVE;
      idx   <= '0;
    end else if (adv) begin
      if (seg_last) begin
        idx <= '0;
        unique case (state)
          SEG_ACTIVE: state <= SEG_FRONT;
          SEG_FRONT:  state <= SEG_SYNC;
          SEG_SYNC:   state <= SEG_BACK;
          SEG_BACK:   state <= SEG_ACTIVE;
          default:    state <= SEG_ACTIVE;
        endcase
      end else begin
        idx <= idx + SEG_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan-out timing: pixel-enable divider plus H/V segment sequencers; optional VGA_VBLANK_IRQ_EN irq.
// Latency: outputs registered, first pixel (0,0) one clk after the first enabled edge.
// Backpressure: none; free-running while vga_en=1, vga_en=0 or rst returns to idle next clk.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input logic               clk,
  input logic               rst,
  vga_timing_ctrl_if.master bus
);

  localparam int             DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam vga_out_t IDLE_OUT = '{
    pix_ce:      1'b0,
    pix_valid:   1'b0,
    pix_x:       '0,
    pix_y:       '0,
    hsync:       ~SYNC_POL,
    vsync:       ~SYNC_POL,
    hblank:      1'b1,
    vblank:      1'b1,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic             clr;
  logic             run;
  logic [DIV_W-1:0] div_cnt;
  logic             ce;

  seg_state_e h_state, v_state;
  seg_cnt_t   h_idx, v_idx;
  logic       h_wrap, unused_v_wrap;

  vga_out_t nxt, out_q;
  logic     h_act, v_act, first_clk;

  assign clr = rst || !bus.vga_en;
  assign ce  = run && (div_cnt == DIV_LAST);

  // run lags vga_en by one clk so the counters hold at (0,0) for the first enabled edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      run     <= 1'b0;
      div_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        div_cnt <= ce ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

  vga_seg_fsm u_h_fsm (
    .clk        (clk),
    .clr        (clr),
    .adv        (ce),
    .len_active (SEG_W'(H_ACTIVE)),
    .len_front  (SEG_W'(H_FP)),
    .len_sync   (SEG_W'(H_SYNC)),
    .len_back   (SEG_W'(H_BP)),
    .state      (h_state),
    .idx        (h_idx),
    .wrap       (h_wrap)
  );

  vga_seg_fsm u_v_fsm (
    .clk        (clk),
    .clr        (clr),
    .adv        (h_wrap),
    .len_active (SEG_W'(V_ACTIVE)),
    .len_front  (SEG_W'(V_FP)),
    .len_sync   (SEG_W'(V_SYNC)),
    .len_back   (SEG_W'(V_BP)),
    .state      (v_state),
    .idx        (v_idx),
    .wrap       (unused_v_wrap)
  );

  assign h_act     = (h_state == SEG_ACTIVE);
  assign v_act     = (v_state == SEG_ACTIVE);
  assign first_clk = h_act && (h_idx == '0) && (div_cnt == '0);

  always_comb begin
    nxt = IDLE_OUT;
    if (run) begin
      nxt.pix_ce      = ce;
      nxt.pix_valid   = h_act && v_act;
      nxt.pix_x       = h_act ? coord_t'(h_idx) : '0;
      nxt.pix_y       = v_act ? coord_t'(v_idx) : '0;
      nxt.hsync       = sync_level(h_state == SEG_SYNC, SYNC_POL);
      nxt.vsync       = sync_level(v_state == SEG_SYNC, SYNC_POL);
      nxt.hblank      = !h_act;
      nxt.vblank      = !v_act;
      nxt.line_start  = first_clk;
      nxt.frame_start = first_clk && v_act && (v_idx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out_q <= IDLE_OUT;
    end else begin
      out_q <= nxt;
    end
  end

  assign bus.pix_ce      = out_q.pix_ce;
  assign bus.pix_valid   = out_q.pix_valid;
  assign bus.pix_x       = out_q.pix_x;
  assign bus.pix_y       = out_q.pix_y;
  assign bus.hsync       = out_q.hsync;
  assign bus.vsync       = out_q.vsync;
  assign bus.hblank      = out_q.hblank;
  assign bus.vblank      = out_q.vblank;
  assign bus.line_start  = out_q.line_start;
  assign bus.frame_start = out_q.frame_start;

`ifdef VGA_VBLANK_IRQ_EN
  logic irq_q;
  logic irq_set;

  // V enters FRONT on the first clk of a line; set wins over a same-clk ack.
  assign irq_set = run && first_clk && (v_state == SEG_FRONT) && (v_idx == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_set || (irq_q && !bus.irq_ack);
    end
  end

  assign bus.irq = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = bus.irq_ack;
  assign bus.irq        = 1'b0;
`endif

endmodule
